// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU memory stage, the DMA/loader and the single-port dmem.
// slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Handshake: a requester raises *_req with we/adr/wd and holds them stable until
  // it sees *_gnt=1 in the same cycle; the access completes in that cycle. Dropping
  // req before a grant cancels the access. Read data is valid only while gnt=1.
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wd;
  logic [DW-1:0] cpu_rd;
  logic          cpu_gnt;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_adr;
  logic [DW-1:0] dma_wd;
  logic [DW-1:0] dma_rd;
  logic          dma_gnt;

  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wd,
    output cpu_rd, cpu_gnt, cpu_stall,
    input  dma_req, dma_we, dma_adr, dma_wd,
    output dma_rd, dma_gnt,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wd,
    input  cpu_rd, cpu_gnt, cpu_stall,
    output dma_req, dma_we, dma_adr, dma_wd,
    input  dma_rd, dma_gnt,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin dmem arbiter (CPU vs DMA) with a burst cap; grants are same-cycle.
// Optional ARB_STATS_EN adds saturating per-requester wait counters.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output logic [1:0]    dbg_own,
  output logic          dbg_last,
  output logic [CW-1:0] dbg_burst_cnt
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_cpu_wait,
  output logic [15:0]   stat_dma_wait
`endif
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } own_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  own_t          own_q, own_nx;
  own_t          last_q, last_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic          gc, gd;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wd;
  logic          sel_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q  <= OWN_IDLE;
      last_q <= OWN_DMA;
      cnt_q  <= '0;
    end else begin
      own_q  <= own_nx;
      last_q <= last_nx;
      cnt_q  <= cnt_nx;
    end
  end

  always_comb begin
    gc      = 1'b0;
    gd      = 1'b0;
    own_nx  = OWN_IDLE;
    last_nx = last_q;
    cnt_nx  = '0;

    if (!reset) begin
      if (bus.cpu_req && !bus.dma_req) begin
        gc = 1'b1;
      end else if (bus.dma_req && !bus.cpu_req) begin
        gd = 1'b1;
      end else if (bus.cpu_req && bus.dma_req) begin
        // Contended: the owner keeps the port until its burst hits the cap.
        case (own_q)
          OWN_CPU: if (cnt_q < CNT_MAX) gc = 1'b1; else gd = 1'b1;
          OWN_DMA: if (cnt_q < CNT_MAX) gd = 1'b1; else gc = 1'b1;
          default: if (last_q == OWN_DMA) gc = 1'b1; else gd = 1'b1;
        endcase
      end
    end

    if (gc) begin
      own_nx  = OWN_CPU;
      last_nx = OWN_CPU;
      cnt_nx  = (own_q == OWN_CPU) ? ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE) : CNT_ONE;
    end else if (gd) begin
      own_nx  = OWN_DMA;
      last_nx = OWN_DMA;
      cnt_nx  = (own_q == OWN_DMA) ? ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE) : CNT_ONE;
    end
  end

  // With no grant the CPU side is presented to the memory, write-disabled.
  always_comb begin
    sel_adr = bus.cpu_adr;
    sel_wd  = bus.cpu_wd;
    sel_we  = 1'b0;
    if (gd) begin
      sel_adr = bus.dma_adr;
      sel_wd  = bus.dma_wd;
      sel_we  = bus.dma_we;
    end else if (gc) begin
      sel_we  = bus.cpu_we;
    end
  end

  assign bus.mem_a     = sel_adr;
  assign bus.mem_wd    = sel_wd;
  assign bus.mem_we    = sel_we;
  assign bus.cpu_gnt   = gc;
  assign bus.dma_gnt   = gd;
  assign bus.cpu_stall = bus.cpu_req & ~gc & ~reset;
  assign bus.cpu_rd    = bus.mem_rd;
  assign bus.dma_rd    = bus.mem_rd;

  assign dbg_own       = own_q;
  assign dbg_last      = (last_q == OWN_DMA);
  assign dbg_burst_cnt = cnt_q;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_wait <= '0;
      stat_dma_wait <= '0;
    end else begin
      if (bus.cpu_req && !gc && stat_cpu_wait != 16'hFFFF) stat_cpu_wait <= stat_cpu_wait + 16'd1;
      if (bus.dma_req && !gd && stat_dma_wait != 16'hFFFF) stat_dma_wait <= stat_dma_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// history-based arbitration model and a shadow memory.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  logic [1:0] dbg_own;
  logic       dbg_last;
  logic [2:0] dbg_burst;
`ifdef ARB_STATS_EN
  logic [15:0] stat_cpu_wait, stat_dma_wait;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .dbg_own       (dbg_own),
    .dbg_last      (dbg_last),
    .dbg_burst_cnt (dbg_burst)
`ifdef ARB_STATS_EN
    ,
    .stat_cpu_wait (stat_cpu_wait),
    .stat_dma_wait (stat_dma_wait)
`endif
  );

  // Behavioural dmem: combinational read, clocked write.
  logic [31:0] tmem [64];
  assign bus.mem_rd = tmem[bus.mem_a[7:2]];
  always @(posedge clk) if (bus.mem_we) tmem[bus.mem_a[7:2]] <= bus.mem_wd;

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] shadow [64];
  logic [31:0] exp_q [$];   // expected read data for granted reads
  int hist [$];             // per-cycle grant history: 0 none, 1 cpu, 2 dma
  int last_w = 2;
  int m_cw = 0, m_dw = 0;

  logic s_cgnt, s_dgnt, s_stall;
  logic [31:0] s_cpu_rd, s_dma_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int model_winner(bit cr, bit dr);
    int prev, run;
    if (!cr && !dr) return 0;
    if (cr && !dr) return 1;
    if (dr && !cr) return 2;
    prev = (hist.size() > 0) ? hist[hist.size()-1] : 0;
    if (prev == 0) return (last_w == 2) ? 1 : 2;
    run = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k] != prev) break;
      run++;
    end
    return (run < MB) ? prev : 3 - prev;
  endfunction

  // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    int w;
    bit cr, dr;
    logic [31:0] e_a, e_wd;
    logic e_we;
    @(negedge clk);
    cr = bus.cpu_req;
    dr = bus.dma_req;
    w  = reset ? 0 : model_winner(cr, dr);
    e_a  = (w == 2) ? bus.dma_adr : bus.cpu_adr;
    e_wd = (w == 2) ? bus.dma_wd  : bus.cpu_wd;
    e_we = (w == 1) ? bus.cpu_we : (w == 2) ? bus.dma_we : 1'b0;
    s_cgnt = bus.cpu_gnt; s_dgnt = bus.dma_gnt; s_stall = bus.cpu_stall;
    s_cpu_rd = bus.cpu_rd; s_dma_rd = bus.dma_rd;
    check("cpu_gnt",   {31'd0, bus.cpu_gnt},   {31'd0, w == 1});
    check("dma_gnt",   {31'd0, bus.dma_gnt},   {31'd0, w == 2});
    check("cpu_stall", {31'd0, bus.cpu_stall}, {31'd0, !reset && cr && w != 1});
    check("mem_we",    {31'd0, bus.mem_we},    {31'd0, e_we});
    check("mem_a",     bus.mem_a,  e_a);
    if (e_we) check("mem_wd", bus.mem_wd, e_wd);
    if (w == 1 && !bus.cpu_we) exp_q.push_back(shadow[bus.cpu_adr[7:2]]);
    if (w == 2 && !bus.dma_we) exp_q.push_back(shadow[bus.dma_adr[7:2]]);
    if (exp_q.size() > 0) check(w == 1 ? "cpu_rd" : "dma_rd", w == 1 ? bus.cpu_rd : bus.dma_rd, exp_q.pop_front());
`ifdef ARB_STATS_EN
    check("stat_cpu_wait", {16'd0, stat_cpu_wait}, 32'(m_cw));
    check("stat_dma_wait", {16'd0, stat_dma_wait}, 32'(m_dw));
    if (reset) begin
      m_cw = 0; m_dw = 0;
    end else begin
      if (cr && w != 1 && m_cw < 65535) m_cw++;
      if (dr && w != 2 && m_dw < 65535) m_dw++;
    end
`endif
    if (reset) begin
      hist.delete();
      last_w = 2;
    end else begin
      hist.push_back(w);
      if (hist.size() > 16) void'(hist.pop_front());
      if (w != 0) last_w = w;
      if (w == 1 && bus.cpu_we) shadow[bus.cpu_adr[7:2]] = bus.cpu_wd;
      if (w == 2 && bus.dma_we) shadow[bus.dma_adr[7:2]] = bus.dma_wd;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cpu(input bit req, input bit we, input logic [31:0] adr, input logic [31:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_adr = adr; bus.cpu_wd = wd;
  endtask

  task automatic drive_dma(input bit req, input bit we, input logic [31:0] adr, input logic [31:0] wd);
    bus.dma_req = req; bus.dma_we = we; bus.dma_adr = adr; bus.dma_wd = wd;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit cpend, dpend;
    for (int i = 0; i < 64; i++) begin
      tmem[i] = 32'(i) * 32'h0101_0101;
      shadow[i] = 32'(i) * 32'h0101_0101;
    end
    drive_cpu(1'b1, 1'b0, 32'h0, 32'h0);
    drive_dma(1'b1, 1'b0, 32'h4, 32'h0);
    do_reset(2);
    check("rst_own",   {30'd0, dbg_own}, 32'd0);
    check("rst_last",  {31'd0, dbg_last}, 32'd1);
    check("rst_burst", {29'd0, dbg_burst}, 32'd0);

    // Uncontended CPU write is granted in the same cycle.
    drive_dma(1'b0, 1'b0, 32'h0, 32'h0);
    drive_cpu(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    step();
    check("t1_gnt",   {31'd0, s_cgnt}, 32'd1);
    check("t1_stall", {31'd0, s_stall}, 32'd0);

    // DMA write then CPU read of the same word.
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    drive_dma(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    step();
    drive_dma(1'b0, 1'b0, 32'h0, 32'h0);
    drive_cpu(1'b1, 1'b0, 32'h20, 32'h0);
    step();
    check("t2_gnt", {31'd0, s_cgnt}, 32'd1);
    check("t2_rd",  s_cpu_rd, 32'h1234_5678);

    // Continuous contention after reset: CPU x4, DMA x4, CPU x4.
    do_reset(1);
    drive_cpu(1'b1, 1'b0, 32'h8, 32'h0);
    drive_dma(1'b1, 1'b0, 32'hC, 32'h0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("t3_cgnt",  {31'd0, s_cgnt},  {31'd0, (i < 4 || i >= 8)});
      check("t3_dgnt",  {31'd0, s_dgnt},  {31'd0, (i >= 4 && i < 8)});
      check("t3_stall", {31'd0, s_stall}, {31'd0, (i >= 4 && i < 8)});
    end

    // CPU owns one cycle then drops; DMA takes over with a fresh burst.
    do_reset(1);
    step();
    check("t4_cgnt", {31'd0, s_cgnt}, 32'd1);
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("t4_dgnt",  {31'd0, s_dgnt}, 32'd1);
    check("t4_burst", {29'd0, dbg_burst}, 32'd1);

    // Reset in the middle of a CPU burst.
    drive_cpu(1'b1, 1'b0, 32'h8, 32'h0);
    do_reset(1);
    step();
    step();
    do_reset(2);
    check("t5_rst_cgnt", {31'd0, s_cgnt}, 32'd0);
    check("t5_rst_dgnt", {31'd0, s_dgnt}, 32'd0);
    step();
    check("t5_cgnt", {31'd0, s_cgnt}, 32'd1);

    // Random traffic with hold-until-grant and occasional cancels/resets.
    cpend = 1'b1; dpend = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (s_cgnt) cpend = 1'b0;
      if (s_dgnt) dpend = 1'b0;
      if (cpend && $urandom_range(0, 15) == 0) cpend = 1'b0;
      if (dpend && $urandom_range(0, 15) == 0) dpend = 1'b0;
      if (!cpend) begin
        cpend = ($urandom_range(0, 2) != 0);
        drive_cpu(cpend, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom);
      end else bus.cpu_req = 1'b1;
      if (!dpend) begin
        dpend = ($urandom_range(0, 2) != 0);
        drive_dma(dpend, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom);
      end else bus.dma_req = 1'b1;
      if (!cpend) bus.cpu_req = 1'b0;
      if (!dpend) bus.dma_req = 1'b0;
      reset = ($urandom_range(0, 199) == 0);
      step();
      if (reset) begin
        reset = 1'b0;
        s_cgnt = 1'b0; s_dgnt = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
